// File: rtl/gfx_pkg.sv
// Shared constants, plane word type and bit-reverse helper for the graphics plane shifter.
package gfx_pkg;

  localparam int unsigned GFX_PLANE_W = 8;

  typedef logic [GFX_PLANE_W-1:0] plane_word_t;

  function automatic plane_word_t bit_reverse(input plane_word_t v);
    plane_word_t r;
    for (int i = 0; i < GFX_PLANE_W; i++) begin
      r[i] = v[GFX_PLANE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ttl_74166_sync.sv
// One bitplane of a synchronous 74LS166: parallel load / shift towards MSB, QH = MSB.
module ttl_74166_sync
  import gfx_pkg::*;
#(
  parameter int unsigned WIDTH = GFX_PLANE_W
) (
  input  logic             Clk,
  input  logic             RESETn,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] D,
  input  logic             SER,
  output logic             QH
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_next;

  // Built by shift-then-patch so WIDTH == 1 needs no special slice.
  always_comb begin
    shift_next    = shreg << 1;
    shift_next[0] = SER;
  end

  always_ff @(posedge Clk) begin
    if (!RESETn) begin
      shreg <= '0;
    end else if (load_en) begin
      shreg <= D;
    end else if (shift_en) begin
      shreg <= shift_next;
    end
  end

  assign QH = shreg[WIDTH-1];

endmodule

// File: rtl/gfx_plane_shifter.sv
// Multi-plane pixel serializer with Cen edge detect, fill counter and reload request.
// Optional horizontal flip at load enabled by defining GFX_PLANE_SHIFTER_FLIP_EN.
module gfx_plane_shifter
  import gfx_pkg::*;
#(
  parameter int unsigned PLANES = 3,
  parameter int unsigned WIDTH  = GFX_PLANE_W
) (
  input  logic                    Clk,
  input  logic                    RESETn,
  input  logic                    Cen,
  input  logic                    LOADn,
  input  logic                    INH,
`ifdef GFX_PLANE_SHIFTER_FLIP_EN
  input  logic                    FLIP,
`endif
  input  logic [PLANES*WIDTH-1:0] D,
  input  logic [PLANES-1:0]       SER,
  output logic [PLANES-1:0]       Q,
  output logic                    EMPTY,
  output logic                    LOAD_REQ
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntFull = CW'(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  logic          last_cen;
  logic          cen_rise;
  logic          load_en;
  logic          shift_en;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign cen_rise = Cen & ~last_cen;
  assign load_en  = cen_rise & ~INH & ~LOADn;
  assign shift_en = cen_rise & ~INH & LOADn;

  always_comb begin
    cnt_next = cnt;
    if (load_en) begin
      cnt_next = '0;
    end else if (shift_en && cnt != CntFull) begin
      cnt_next = cnt + CW'(1);
    end
  end

  // last_cen resets high so a Cen already high at release is not an edge.
  always_ff @(posedge Clk) begin
    if (!RESETn) begin
      last_cen <= 1'b1;
      cnt      <= CntFull;
      LOAD_REQ <= 1'b0;
    end else begin
      last_cen <= Cen;
      cnt      <= cnt_next;
      LOAD_REQ <= (load_en | shift_en) && (cnt_next == CntLast);
    end
  end

  assign EMPTY = (cnt == CntFull);

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic [WIDTH-1:0] d_plane;
    logic [WIDTH-1:0] d_load;

    assign d_plane = D[p*WIDTH +: WIDTH];

`ifdef GFX_PLANE_SHIFTER_FLIP_EN
    logic [WIDTH-1:0] d_rev;
    if (WIDTH == GFX_PLANE_W) begin : g_rev_pkg
      assign d_rev = bit_reverse(d_plane);
    end else begin : g_rev_loop
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign d_rev[i] = d_plane[WIDTH-1-i];
      end
    end
    assign d_load = FLIP ? d_rev : d_plane;
`else
    assign d_load = d_plane;
`endif

    ttl_74166_sync #(
      .WIDTH(WIDTH)
    ) u_plane (
      .Clk     (Clk),
      .RESETn  (RESETn),
      .load_en (load_en),
      .shift_en(shift_en),
      .D       (d_load),
      .SER     (SER[p]),
      .QH      (Q[p])
    );
  end

endmodule
